imm_ext_pipe: RTL and testbench

//   Parametrised, registered immediate extender for the ID->EX boundary of the CPU datapath.

---
 rtl/imm_ext_pipe.sv | 73 +++++++
 tb/tb_imm_ext_pipe.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered ID->EX immediate extender with a 2-entry skid buffer and flush.
// Ports: clk, rst_n (async active-low), flush (sync kill of all entries),
//   in_valid/in_ready/in_imm[IN_W]/in_mode[2]/in_tag[TAG_W] upstream handshake,
//   out_valid/out_ready/out_imm[OUT_W]/out_tag[TAG_W] downstream handshake.
// Modes: 00 zero-ext, 01 sign-ext, 10 upper, 11 branch offset (sign-ext << 2)
//   when IMM_EXT_SHIFT_EN is defined, otherwise identical to zero-ext.
module imm_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic [TAG_W-1:0] out_tag
);
  logic [OUT_W-1:0] zx, sx, up, br, ext;
  logic [OUT_W-1:0] m_imm, s_imm;
  logic [TAG_W-1:0] m_tag, s_tag;
  logic             m_valid, s_valid;
  assign zx = {{(OUT_W-IN_W){1'b0}}, in_imm};
  assign sx = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
  assign up = {in_imm, {(OUT_W-IN_W){1'b0}}};
`ifdef IMM_EXT_SHIFT_EN
  assign br = sx << 2;
`else
  assign br = zx;
`endif
  always_comb ext = in_mode == 2'b01 ? sx : in_mode == 2'b10 ? up : in_mode == 2'b11 ? br : zx;
  // Ready comes straight from the skid flag, so it never depends on out_ready combinationally.
  assign in_ready  = !s_valid;
  assign out_valid = m_valid;
  assign out_imm   = m_imm;
  assign out_tag   = m_tag;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_imm   <= '0;
      m_tag   <= '0;
      s_imm   <= '0;
      s_tag   <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (!m_valid || out_ready) begin
      // M is free this cycle: refill from S first to keep order; S full implies no accept.
      if (s_valid) begin
        m_imm   <= s_imm;
        m_tag   <= s_tag;
        m_valid <= 1'b1;
        s_valid <= 1'b0;
      end else begin
        m_valid <= in_valid;
        if (in_valid) begin
          m_imm <= ext;
          m_tag <= in_tag;
        end
      end
    end else if (in_valid && !s_valid) begin
      s_imm   <= ext;
      s_tag   <= in_tag;
      s_valid <= 1'b1;
    end
endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: directed bench with a queue-based reference model and literal expectations.
module tb_imm_ext_pipe;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] in_imm = '0;
  logic [1:0]  in_mode = '0;
  logic [4:0]  in_tag = '0;
  logic        in_ready, out_valid;
  logic [31:0] out_imm;
  logic [4:0]  out_tag;
  int checks = 0, errors = 0;

  typedef struct {logic [31:0] imm; logic [4:0] tag;} ent_t;
  ent_t q[$];

  imm_ext_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_ext(logic [15:0] imm, logic [1:0] mode);
    int s = imm[15] ? int'(imm) - 65536 : int'(imm);
    case (mode)
      2'b00: return 32'(imm);
      2'b01: return 32'(s);
      2'b10: return 32'(imm) * 32'd65536;
`ifdef IMM_EXT_SHIFT_EN
      default: return 32'(s * 4);
`else
      default: return 32'(imm);
`endif
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a FIFO of at most two entries; the head is what the output must show.
  always @(negedge rst_n) q.delete();
  always @(posedge clk) begin
    if (!rst_n || flush) q.delete();
    else begin
      automatic bit acc = in_valid && q.size() < 2;
      automatic ent_t e;
      e.imm = model_ext(in_imm, in_mode);
      e.tag = in_tag;
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
  end

  always @(negedge clk) if (rst_n) begin
    chk("model_out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("model_in_ready", 32'(in_ready), 32'(q.size() < 2));
    if (out_valid && q.size() > 0) begin
      chk("model_out_imm", out_imm, q[0].imm);
      chk("model_out_tag", 32'(out_tag), 32'(q[0].tag));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [15:0] imm, logic [1:0] mode, logic [4:0] tag);
    in_valid = 1'b1; in_imm = imm; in_mode = mode; in_tag = tag;
    tick();
    in_valid = 1'b0;
  endtask

  logic [15:0] mix_ready = 16'b1011_0010_1100_1101;
  logic [15:0] mix_valid = 16'b1110_1101_0111_1011;

  initial begin
    #2;
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_in_ready", 32'(in_ready), 1);
    chk("reset_out_imm", out_imm, 0);
    chk("reset_out_tag", 32'(out_tag), 0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    send(16'h8001, 2'b00, 5'd1); chk("mode00", out_imm, 32'h0000_8001);
    send(16'h8001, 2'b01, 5'd2); chk("mode01", out_imm, 32'hFFFF_8001);
    send(16'h8001, 2'b10, 5'd3); chk("mode10", out_imm, 32'h8001_0000);
    send(16'hFFFF, 2'b11, 5'd4);
`ifdef IMM_EXT_SHIFT_EN
    chk("mode11", out_imm, 32'hFFFF_FFFC);
`else
    chk("mode11", out_imm, 32'h0000_FFFF);
`endif
    send(16'h1234, 2'b01, 5'd5); chk("mode01_pos", out_imm, 32'h0000_1234);
    tick();
    chk("drained", 32'(out_valid), 0);
    out_ready = 1'b0;
    send(16'h0011, 2'b00, 5'd1);
    chk("bp_ready_1", 32'(in_ready), 1);
    send(16'h0022, 2'b00, 5'd2);
    chk("bp_ready_2", 32'(in_ready), 0);
    chk("bp_head", 32'(out_tag), 1);
    tick();
    chk("bp_stable", 32'(out_tag), 1);
    out_ready = 1'b1;
    tick();
    chk("bp_tag2", 32'(out_tag), 2);
    chk("bp_valid2", 32'(out_valid), 1);
    tick();
    chk("bp_empty", 32'(out_valid), 0);
    out_ready = 1'b0;
    send(16'h0003, 2'b00, 5'd3);
    send(16'h0004, 2'b00, 5'd4);
    flush = 1'b1;
    send(16'h0005, 2'b00, 5'd5);
    flush = 1'b0;
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    tick();
    chk("flush_no_tag5", 32'(out_valid), 0);
    out_ready = 1'b0;
    send(16'h0006, 2'b00, 5'd6);
    flush = 1'b1;
    send(16'h0007, 2'b00, 5'd7);
    flush = 1'b0;
    chk("flush_ready_hi", 32'(out_valid), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_imm = 16'(i * 3); in_mode = 2'(i); in_tag = 5'(i);
      tick();
      chk("stream_valid", 32'(out_valid), 1);
      chk("stream_tag", 32'(out_tag), i);
      chk("stream_ready", 32'(in_ready), 1);
    end
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      out_ready = mix_ready[i];
      in_valid = mix_valid[i]; in_imm = 16'(16'h7F00 + i * 16'h0135); in_mode = 2'(i + 1); in_tag = 5'(i + 8);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    send(16'h00AA, 2'b00, 5'd9);
    send(16'h00BB, 2'b00, 5'd10);
    chk("full_before_reset", 32'(in_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 0);
    chk("async_in_ready", 32'(in_ready), 1);
    chk("async_out_imm", out_imm, 0);
    #1 rst_n = 1'b1;
    send(16'h8001, 2'b01, 5'd11);
    chk("post_reset_accept", 32'(out_valid), 1);
    chk("post_reset_imm", out_imm, 32'hFFFF_8001);
    out_ready = 1'b1;
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
